play_audio: RTL and testbench



---
 rtl/play_audio_pkg.sv | 27 ++
 rtl/sample_tick_gen.sv | 39 +++
 rtl/play_audio.sv | 139 +++++++++++++
 tb/tb_play_audio.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/play_audio_pkg.sv
// Shared types and default clip map for the sound-effect sequencer.
// Contents:
//   state_e        sequencer state (idle plus one play state per effect)
//   Def*           default sample divider and per-clip ROM base / sample count
package play_audio_pkg;

  typedef enum logic [2:0] {
    StHold,
    StPlayStart,
    StPlayChomp,
    StPlayEatghost,
    StPlayDeath
  } state_e;

  // 50 MHz / 48 kHz
  localparam int unsigned DefSampleDiv   = 1042;

  localparam int unsigned DefStartBase    = 0;
  localparam int unsigned DefStartLen     = 24000;
  localparam int unsigned DefChompBase    = 24000;
  localparam int unsigned DefChompLen     = 4000;
  localparam int unsigned DefEatghostBase = 28000;
  localparam int unsigned DefEatghostLen  = 8000;
  localparam int unsigned DefDeathBase    = 36000;
  localparam int unsigned DefDeathLen     = 29536;

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-rate divider: counts 0..SAMPLE_DIV-1 and wraps, pulsing tick for one
// cycle when the count reaches SAMPLE_DIV-1.
// Ports:
//   CLOCK_50  system clock
//   reset     asynchronous active-low reset
//   clear     synchronous clear; holds the count at 0 and suppresses tick
//   tick      single-cycle pulse on the last count of each sample period
module sample_tick_gen #(
  parameter int unsigned SAMPLE_DIV = 1042
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CntW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(SAMPLE_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (clear || (cnt_q == CntLast)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = !clear && (cnt_q == CntLast);

endmodule

// File: rtl/play_audio.sv
// Sound-effect sequencer: on a game trigger, steps through that effect's clip in
// an external 8-bit sample ROM at one sample per SAMPLE_DIV cycles and streams
// the samples to the codec as 24-bit signed PCM. Silence is streamed when idle.
// Ports:
//   CLOCK_50                       system clock
//   reset                          asynchronous active-low reset
//   start, chomp, eatghost, death  effect triggers, only looked at when idle
//   rom_addr                       sample ROM address
//   rom_data                       ROM output, offset-binary, one cycle after rom_addr
//   write_ready                    codec FIFO can accept a sample pair
//   write                          codec write strobe
//   writedata_left/right           PCM sample (right mirrors left)
//   busy                           a clip is playing
module play_audio
  import play_audio_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV    = DefSampleDiv,
  parameter int unsigned START_BASE    = DefStartBase,
  parameter int unsigned START_LEN     = DefStartLen,
  parameter int unsigned CHOMP_BASE    = DefChompBase,
  parameter int unsigned CHOMP_LEN     = DefChompLen,
  parameter int unsigned EATGHOST_BASE = DefEatghostBase,
  parameter int unsigned EATGHOST_LEN  = DefEatghostLen,
  parameter int unsigned DEATH_BASE    = DefDeathBase,
  parameter int unsigned DEATH_LEN     = DefDeathLen
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        start,
  input  logic        chomp,
  input  logic        eatghost,
  input  logic        death,
  output logic [15:0] rom_addr,
  input  logic [7:0]  rom_data,
  input  logic        write_ready,
  output logic        write,
  output logic [23:0] writedata_left,
  output logic [23:0] writedata_right,
  output logic        busy
);

  localparam logic [15:0] StartBase    = 16'(START_BASE);
  localparam logic [15:0] StartLast    = 16'(START_LEN - 1);
  localparam logic [15:0] ChompBase    = 16'(CHOMP_BASE);
  localparam logic [15:0] ChompLast    = 16'(CHOMP_LEN - 1);
  localparam logic [15:0] EatghostBase = 16'(EATGHOST_BASE);
  localparam logic [15:0] EatghostLast = 16'(EATGHOST_LEN - 1);
  localparam logic [15:0] DeathBase    = 16'(DEATH_BASE);
  localparam logic [15:0] DeathLast    = 16'(DEATH_LEN - 1);

  state_e      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] idx_q, idx_d;
  logic [15:0] clip_base, clip_last;
  logic [23:0] wd_q;
  logic        tick;
  logic        in_hold;

  assign in_hold = (state_q == StHold);

  // Held in clear while idle so every clip starts with a full sample period.
  sample_tick_gen #(
    .SAMPLE_DIV(SAMPLE_DIV)
  ) u_sample_tick_gen (
    .CLOCK_50(CLOCK_50),
    .reset   (reset),
    .clear   (in_hold),
    .tick    (tick)
  );

  // Clip map for the effect currently playing.
  always_comb begin
    clip_base = '0;
    clip_last = '0;
    unique case (state_q)
      StPlayStart:    begin clip_base = StartBase;    clip_last = StartLast;    end
      StPlayChomp:    begin clip_base = ChompBase;    clip_last = ChompLast;    end
      StPlayEatghost: begin clip_base = EatghostBase; clip_last = EatghostLast; end
      StPlayDeath:    begin clip_base = DeathBase;    clip_last = DeathLast;    end
      default:        ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    if (in_hold) begin
      addr_d = '0;
      idx_d  = '0;
      // Fixed priority: start > chomp > eatghost > death.
      if (start) begin
        state_d = StPlayStart;
        addr_d  = StartBase;
      end else if (chomp) begin
        state_d = StPlayChomp;
        addr_d  = ChompBase;
      end else if (eatghost) begin
        state_d = StPlayEatghost;
        addr_d  = EatghostBase;
      end else if (death) begin
        state_d = StPlayDeath;
        addr_d  = DeathBase;
      end
    end else if (tick) begin
      if (idx_q == clip_last) begin
        state_d = StHold;
        addr_d  = '0;
        idx_d   = '0;
      end else begin
        idx_d  = idx_q + 16'd1;
        addr_d = clip_base + idx_q + 16'd1;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q <= StHold;
      addr_q  <= '0;
      idx_q   <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      // Flipping the MSB turns offset-binary into two's complement.
      wd_q    <= in_hold ? 24'h0 : {rom_data ^ 8'h80, 16'h0000};
    end
  end

  assign rom_addr        = addr_q;
  assign writedata_left  = wd_q;
  assign writedata_right = wd_q;
  assign busy            = !in_hold;
  // reset is active-low, so this gates the strobe off while in reset.
  assign write           = write_ready & reset;

endmodule

// File: tb/tb_play_audio.sv
module tb_play_audio;

  localparam int Div = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, chomp, eatghost, death;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data = 8'h80;
  logic        write_ready;
  logic        write;
  logic [23:0] writedata_left, writedata_right;
  logic        busy;

  int vectors = 0;
  int fails   = 0;

  play_audio #(
    .SAMPLE_DIV   (Div),
    .START_BASE   (0),
    .START_LEN    (3),
    .CHOMP_BASE   (3),
    .CHOMP_LEN    (2),
    .EATGHOST_BASE(5),
    .EATGHOST_LEN (2),
    .DEATH_BASE   (7),
    .DEATH_LEN    (2)
  ) dut (
    .CLOCK_50       (clk),
    .reset          (reset),
    .start          (start),
    .chomp          (chomp),
    .eatghost       (eatghost),
    .death          (death),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .write_ready    (write_ready),
    .write          (write),
    .writedata_left (writedata_left),
    .writedata_right(writedata_right),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // Behavioural 1-cycle ROM: data = address + 0x80.
  always_ff @(posedge clk) rom_data <= rom_addr[7:0] + 8'h80;

  // Expected values k cycles after the edge that accepted a trigger.
  function automatic logic e_busy(int len, int k);
    return (k >= 0) && (k < len * Div);
  endfunction

  function automatic logic [15:0] e_addr(int base, int len, int k);
    return e_busy(len, k) ? 16'(base + k / Div) : 16'h0;
  endfunction

  // Sample of address k-2, valid only if the state before edge k was a play state.
  function automatic logic [23:0] e_wd(int base, int len, int k);
    logic [15:0] a;
    a = e_addr(base, len, k - 2);
    return (k >= 1 && e_busy(len, k - 1)) ? {a[7:0], 16'h0} : 24'h0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; write_ready = 1'b0;
    start = 1'b0; chomp = 1'b0; eatghost = 1'b0; death = 1'b0;
    step(); step();
    vectors++;
    if ({rom_addr, busy, write} !== {16'h0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_ctl got addr=%h busy=%b write=%b want 0 0 0", rom_addr, busy, write);
    end
    vectors++;
    if ({writedata_left, writedata_right} !== 48'h0) begin
      fails++;
      $display("FAIL reset_wd got %h/%h want 0/0", writedata_left, writedata_right);
    end
    write_ready = 1'b1;
    #1;
    vectors++;
    if (write !== 1'b0) begin
      fails++;
      $display("FAIL reset_write_gated got %b want 0", write);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if ({write, writedata_left} !== {1'b1, 24'h0}) begin
      fails++;
      $display("FAIL release got write=%b wd=%h want 1 000000", write, writedata_left);
    end
    step();
    vectors++;
    if ({busy, rom_addr} !== {1'b0, 16'h0}) begin
      fails++;
      $display("FAIL idle got busy=%b addr=%h want 0 0000", busy, rom_addr);
    end
  endtask

  task automatic test_start_clip();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k <= 13; k++) begin
      vectors++;
      if (rom_addr !== e_addr(0, 3, k)) begin
        fails++;
        $display("FAIL start_addr k=%0d got %h want %h", k, rom_addr, e_addr(0, 3, k));
      end
      vectors++;
      if (busy !== e_busy(3, k)) begin
        fails++;
        $display("FAIL start_busy k=%0d got %b want %b", k, busy, e_busy(3, k));
      end
      vectors++;
      if ({writedata_left, writedata_right} !== {e_wd(0, 3, k), e_wd(0, 3, k)}) begin
        fails++;
        $display("FAIL start_wd k=%0d got %h/%h want %h", k, writedata_left, writedata_right,
                 e_wd(0, 3, k));
      end
      step();
    end
  endtask

  task automatic test_priority();
    chomp = 1'b1; death = 1'b1;
    step();
    chomp = 1'b0; death = 1'b0;
    for (int k = 0; k <= 9; k++) begin
      vectors++;
      if ({busy, rom_addr} !== {e_busy(2, k), e_addr(3, 2, k)}) begin
        fails++;
        $display("FAIL prio_addr k=%0d got busy=%b addr=%h want %b %h", k, busy, rom_addr,
                 e_busy(2, k), e_addr(3, 2, k));
      end
      vectors++;
      if (writedata_left !== e_wd(3, 2, k)) begin
        fails++;
        $display("FAIL prio_wd k=%0d got %h want %h", k, writedata_left, e_wd(3, 2, k));
      end
      step();
    end
  endtask

  task automatic test_no_preempt();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k <= 12; k++) begin
      vectors++;
      if ({busy, rom_addr} !== {e_busy(3, k), e_addr(0, 3, k)}) begin
        fails++;
        $display("FAIL nopre_start k=%0d got busy=%b addr=%h want %b %h", k, busy, rom_addr,
                 e_busy(3, k), e_addr(0, 3, k));
      end
      if (k == 5) eatghost = 1'b1;
      if (k == 6) eatghost = 1'b0;
      if (k == 8) eatghost = 1'b1;
      step();
    end
    eatghost = 1'b0;
    for (int k = 0; k <= 9; k++) begin
      vectors++;
      if ({busy, rom_addr} !== {e_busy(2, k), e_addr(5, 2, k)}) begin
        fails++;
        $display("FAIL retrig_addr k=%0d got busy=%b addr=%h want %b %h", k, busy, rom_addr,
                 e_busy(2, k), e_addr(5, 2, k));
      end
      vectors++;
      if (writedata_right !== e_wd(5, 2, k)) begin
        fails++;
        $display("FAIL retrig_wd k=%0d got %h want %h", k, writedata_right, e_wd(5, 2, k));
      end
      step();
    end
  endtask

  task automatic test_reset_mid_clip();
    death = 1'b1;
    step();
    death = 1'b0;
    vectors++;
    if ({busy, rom_addr} !== {1'b1, 16'h0007}) begin
      fails++;
      $display("FAIL death_entry got busy=%b addr=%h want 1 0007", busy, rom_addr);
    end
    step(); step();
    vectors++;
    if (writedata_left !== 24'h070000) begin
      fails++;
      $display("FAIL death_wd got %h want 070000", writedata_left);
    end
    #2 reset = 1'b0;
    #1;
    vectors++;
    if ({busy, rom_addr, writedata_left, write} !== {1'b0, 16'h0, 24'h0, 1'b0}) begin
      fails++;
      $display("FAIL async_reset got busy=%b addr=%h wd=%h write=%b want 0 0000 000000 0",
               busy, rom_addr, writedata_left, write);
    end
    step(); step();
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      vectors++;
      if ({busy, rom_addr, writedata_left} !== {1'b0, 16'h0, 24'h0}) begin
        fails++;
        $display("FAIL no_resume k=%0d got busy=%b addr=%h wd=%h want 0 0000 000000",
                 k, busy, rom_addr, writedata_left);
      end
    end
  endtask

  task automatic test_write_ready();
    write_ready = 1'b0;
    #1;
    vectors++;
    if (write !== 1'b0) begin
      fails++;
      $display("FAIL wr_hold_0 got %b want 0", write);
    end
    write_ready = 1'b1;
    #1;
    vectors++;
    if (write !== 1'b1) begin
      fails++;
      $display("FAIL wr_hold_1 got %b want 1", write);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    write_ready = 1'b0;
    #1;
    vectors++;
    if ({busy, write} !== {1'b1, 1'b0}) begin
      fails++;
      $display("FAIL wr_play_0 got busy=%b write=%b want 1 0", busy, write);
    end
    write_ready = 1'b1;
    #1;
    vectors++;
    if (write !== 1'b1) begin
      fails++;
      $display("FAIL wr_play_1 got %b want 1", write);
    end
    for (int k = 0; k < 13; k++) step();
    vectors++;
    if ({busy, rom_addr, write} !== {1'b0, 16'h0, 1'b1}) begin
      fails++;
      $display("FAIL wr_end got busy=%b addr=%h write=%b want 0 0000 1", busy, rom_addr, write);
    end
  endtask

  initial begin
    test_reset();
    test_start_clip();
    test_priority();
    test_no_preempt();
    test_reset_mid_clip();
    test_write_ready();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
